ifns_8di_decoder_pipe: RTL
==========================

// Module: ifns_8di_decoder_pipe
// PURPOSE
//   Receive-side IFNS decoder: converts 11-bit IFNS codewords d[11:1] back to 8-bit data v[7:0].
//   Sits at the bus receiver, paired with the 8-bit IFNS encoder core at the transmitter.
//   v = sum(d[i]*W[i]), with W[11:1] = {144,55,34,21,13,8,5,3,2,1,1}.
//   Two-stage valid/ready pipeline; full throughput of one codeword per clock.
// PARAMETERS
//   CNT_W   8   width of saturating error counter (used only when IFNS_DEC_ERRCHK_EN is defined)
// PORTS
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   cw_i       in   11     codeword; bit k-1 carries d[k] (cw_i[10]=d11 ... cw_i[0]=d1)
//   cw_vld_i   in   1      cw_i valid
//   cw_rdy_o   out  1      decoder can accept cw_i this cycle
//   data_o     out  8      decoded data v
//   data_vld_o out  1      data_o valid
//   data_rdy_i in   1      downstream accepts data_o
//   err_o      out  1      decoded sum exceeded 255 (qualified by data_vld_o)
//   err_cnt_o  out  CNT_W  count of accepted codewords that had an error
// BEHAVIOUR
//   Reset: all valid flags, data_o, err_o, err_cnt_o -> 0; pipeline empty.
//   Transfer on an input occurs when cw_vld_i && cw_rdy_o; on the output when data_vld_o && data_rdy_i.
//   S1 (register): hi = 144*d11+55*d10+34*d9+21*d8+13*d7 (9 bits, max 267);
//                  lo = 8*d6+5*d5+3*d4+2*d3+d2+d1 (5 bits, max 20). S1 valid flag v1.
//   S2 (register): sum = hi+lo (9 bits, max 287); data_o = sum[7:0]; err_o = (sum>255). Flag v2 = data_vld_o.
//   Latency: a codeword accepted in cycle N is presented on data_o in cycle N+2 if the pipeline is not stalled.
//   Stall rule: S2 loads when !v2 || data_rdy_i; S1 loads when !v1 || S2 loads.
//   cw_rdy_o = !v1 || !v2 || data_rdy_i (combinational; no bubble at full throughput).
//   Held data: while data_vld_o && !data_rdy_i, data_o and err_o hold stable; a stage register is never overwritten while it is full and not draining.
//   Simultaneous accept and drain in the same cycle: both take place; occupancy stays constant.
//   Stages load only on a transfer; a stage with its valid flag low still holds its last data.
//   Any 11-bit pattern is decoded arithmetically; no check for encoder-legal patterns.
//   Reset asserted mid-operation: in-flight codewords are dropped; no output beat is produced for them.
// CONFIGURATION
//   IFNS_DEC_ERRCHK_EN defined:
//     - err_o is computed as above.
//     - err_cnt_o increments on each output transfer with err_o=1.
//     - err_cnt_o saturates at all-ones and does not wrap.
//   IFNS_DEC_ERRCHK_EN undefined:
//     - err_o and err_cnt_o are tied to 0.
//     - No compare or counter logic is built.
//     - data_o is still sum[7:0] (low 8 bits on overflow).
// TESTING
//   1 Reset:
//     - Drive rst_n=0 mid-stream -> data_vld_o=0, err_o=0 and err_cnt_o=0 asynchronously.
//     - Then cw_rdy_o=1 after release.
//   2 Known codewords, data_rdy_i=1:
//     - cw_i=0x000 -> data_o=0; 0x601 -> 200; 0x781 -> 255.
//     - Each result appears 2 cycles after its input transfer; err_o=0.
//   3 Exhaustive round trip:
//     - Encoder output for v=0..255, one beat per cycle -> data_o=v in order.
//     - 256 consecutive output beats, cw_rdy_o never drops.
//   4 Backpressure:
//     - Hold data_rdy_i=0 for 5 cycles while streaming.
//     - Expect cw_rdy_o=0 after 2 beats are held, data_o stable, no beat lost or duplicated after release.
//   5 Overflow, with the macro defined:
//     - cw_i=0x7FF -> data_o=0x1F, err_o=1, err_cnt_o +1.
//     - With CNT_W=2, send 5 such beats -> err_cnt_o=3.
//   6 Overflow, macro undefined: cw_i=0x7FF -> data_o=0x1F, err_o=0, err_cnt_o=0.

Source files
------------

// File: rtl/ifns_8di_decoder_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifns_8di_decoder_pipe : 2-stage valid/ready IFNS 11-bit -> 8-bit decoder  |
// | Option macro IFNS_DEC_ERRCHK_EN adds overflow flag + saturating counter.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module ifns_8di_decoder_pipe #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      cw_i,
  input  logic             cw_vld_i,
  output logic             cw_rdy_o,
  output logic [7:0]       data_o,
  output logic             data_vld_o,
  input  logic             data_rdy_i,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  // Without the error check only the low 8 bits of the sum are observable,
  // so the upper partial sum is kept one bit narrower.
`ifdef IFNS_DEC_ERRCHK_EN
  localparam int HI_W = 9;
`else
  localparam int HI_W = 8;
`endif

  logic            v1_q, v1_d;
  logic            v2_q, v2_d;
  logic [HI_W-1:0] hi_q, hi_d;
  logic [4:0]      lo_q, lo_d;
  logic [7:0]      data_q, data_d;
  logic            s1_load, s2_load, in_xfer;
  logic [HI_W-1:0] sum;

  always_comb begin
    s2_load = !v2_q || data_rdy_i;
    s1_load = !v1_q || s2_load;
    in_xfer = cw_vld_i && s1_load;
    sum     = hi_q + HI_W'(lo_q);

    v1_d = s1_load ? cw_vld_i : v1_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (in_xfer) begin
      hi_d = (cw_i[10] ? HI_W'(144) : HI_W'(0))
           + (cw_i[9]  ? HI_W'(55)  : HI_W'(0))
           + (cw_i[8]  ? HI_W'(34)  : HI_W'(0))
           + (cw_i[7]  ? HI_W'(21)  : HI_W'(0))
           + (cw_i[6]  ? HI_W'(13)  : HI_W'(0));
      lo_d = (cw_i[5] ? 5'd8 : 5'd0)
           + (cw_i[4] ? 5'd5 : 5'd0)
           + (cw_i[3] ? 5'd3 : 5'd0)
           + (cw_i[2] ? 5'd2 : 5'd0)
           + {4'd0, cw_i[1]} + {4'd0, cw_i[0]};
    end

    v2_d   = s2_load ? v1_q : v2_q;
    data_d = (s2_load && v1_q) ? sum[7:0] : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      data_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      data_q <= data_d;
    end
  end

  assign cw_rdy_o   = s1_load;
  assign data_o     = data_q;
  assign data_vld_o = v2_q;

`ifdef IFNS_DEC_ERRCHK_EN
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter advances only when an erroneous beat actually leaves the decoder.
  always_comb begin
    err_d = (s2_load && v1_q) ? sum[8] : err_q;
    cnt_d = cnt_q;
    if (v2_q && data_rdy_i && err_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;
`else
  assign err_o     = 1'b0;
  assign err_cnt_o = '0;
`endif

endmodule
`default_nettype wire
